// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: command FIFO, alu issue and registered result stage for the
// combinational alu. Holds an accumulator so chained operations (acc = acc op B)
// run without a round trip through the producer.
// Optional build macro ALU_ISSUE_CTRL_STATS_EN adds issue/carry/stall counters.

module alu_issue_ctrl #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   in_op,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_use_acc,
    input  logic         in_wb,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [3:0]   alu_op,
    input  logic [W-1:0] alu_y,
    input  logic         alu_carry,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_y,
    output logic         out_carry,
    output logic [W-1:0] acc,
    output logic         busy
`ifdef ALU_ISSUE_CTRL_STATS_EN
    ,
    output logic [31:0]  issue_cnt,
    output logic [31:0]  carry_cnt,
    output logic [31:0]  stall_cnt
`endif
);

    // state  | meaning
    // IDLE   | FIFO empty, no result held
    // RUN    | FIFO non-empty and the output stage can take a result (issuing)
    // STALL  | result held, consumer not ready, commands waiting
    // DRAIN  | result held, FIFO empty
    // The state is a pure decode of count/out_valid/out_ready; no extra flops.

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [3:0] OP_CLR = 4'hE;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_STALL,
        S_DRAIN
    } state_t;

    state_t state;

    logic [3:0]   fifo_op     [DEPTH];
    logic [W-1:0] fifo_a      [DEPTH];
    logic [W-1:0] fifo_b      [DEPTH];
    logic         fifo_use_acc[DEPTH];
    logic         fifo_wb     [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic empty;
    logic push;
    logic issue;

    assign empty    = (count == '0);
    assign in_ready = (count < CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign issue    = !empty && (!out_valid || out_ready);

    // State decode; busy is simply "not idle".
    always_comb begin
        state = S_IDLE;
        if (!empty) begin
            state = (out_valid && !out_ready) ? S_STALL : S_RUN;
        end else if (out_valid) begin
            state = S_DRAIN;
        end
    end

    assign busy = (state != S_IDLE);

    // alu drive from the FIFO head; a CLR with zero operands when nothing is queued.
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = OP_CLR;
        if (!empty) begin
            alu_a  = fifo_use_acc[rd_ptr] ? acc : fifo_a[rd_ptr];
            alu_b  = fifo_b[rd_ptr];
            alu_op = fifo_op[rd_ptr];
        end
    end

    // FIFO storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_op[wr_ptr]      <= in_op;
            fifo_a[wr_ptr]       <= in_a;
            fifo_b[wr_ptr]       <= in_b;
            fifo_use_acc[wr_ptr] <= in_use_acc;
            fifo_wb[wr_ptr]      <= in_wb;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (issue) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, issue})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Output stage: capture the alu result on issue, clear valid once consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_y     <= '0;
            out_carry <= 1'b0;
        end else if (issue) begin
            out_valid <= 1'b1;
            out_y     <= alu_y;
            out_carry <= alu_carry;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Accumulator writeback at the issue edge, so the next head already sees it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (issue && fifo_wb[rd_ptr]) begin
            acc <= alu_y;
        end
    end

`ifdef ALU_ISSUE_CTRL_STATS_EN
    // Free-running event counters, wrapping at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt <= '0;
            carry_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (issue) begin
                issue_cnt <= issue_cnt + 32'd1;
            end
            if (issue && alu_carry) begin
                carry_cnt <= carry_cnt + 32'd1;
            end
            if (state == S_STALL) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a small behavioural alu in the loop.
module tb_alu_issue_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   in_op;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_use_acc;
    logic         in_wb;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [3:0]   alu_op;
    logic [W-1:0] alu_y;
    logic         alu_carry;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_y;
    logic         out_carry;
    logic [W-1:0] acc;
    logic         busy;
`ifdef ALU_ISSUE_CTRL_STATS_EN
    logic [31:0]  issue_cnt;
    logic [31:0]  carry_cnt;
    logic [31:0]  stall_cnt;
`endif

    alu_issue_ctrl #(.W(W), .DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_use_acc (in_use_acc),
        .in_wb      (in_wb),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_y      (alu_y),
        .alu_carry  (alu_carry),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_y      (out_y),
        .out_carry  (out_carry),
        .acc        (acc),
        .busy       (busy)
`ifdef ALU_ISSUE_CTRL_STATS_EN
        ,
        .issue_cnt  (issue_cnt),
        .carry_cnt  (carry_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural alu: ADD, SUB (carry = no borrow), CLR, PASS A.
    always_comb begin
        alu_y     = '0;
        alu_carry = 1'b0;
        case (alu_op)
            4'h0: {alu_carry, alu_y} = {1'b0, alu_a} + {1'b0, alu_b};
            4'h1: begin
                alu_y     = alu_a - alu_b;
                alu_carry = (alu_a >= alu_b);
            end
            4'hE: alu_y = '0;
            4'hF: alu_y = alu_a;
            default: alu_y = '0;
        endcase
    end

    int total = 0;
    int bad   = 0;

    logic [W:0] sb[$];   // {carry, y}

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pop and compare on every output handshake; check hold during stalls.
    logic         hold_v = 1'b0;
    logic [W:0]   hold_d;
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v && out_valid) chk("hold", {out_carry, out_y}, hold_d);
            hold_v = 1'b0;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", {out_carry, out_y}, 32'hDEAD);
                end else begin
                    chk("result", {out_carry, out_y}, sb.pop_front());
                end
            end else if (out_valid) begin
                hold_v = 1'b1;
                hold_d = {out_carry, out_y};
            end
        end
    end

    // Call just after a posedge; returns just after the accepting posedge.
    task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic use_acc, input logic wb,
                        input logic [W-1:0] ey, input logic ec);
        bit done = 0;
        in_valid   = 1'b1;
        in_op      = op;
        in_a       = a;
        in_b       = b;
        in_use_acc = use_acc;
        in_wb      = wb;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back({ec, ey});
                done = 1;
            end
        end
        if (!done) chk("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0) done = 1;
        end
        if (!done) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_op      = 4'h0;
        in_a       = '0;
        in_b       = '0;
        in_use_acc = 1'b0;
        in_wb      = 1'b0;
        out_ready  = 1'b1;
        #12 rst_n  = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_acc", acc, 0);
        chk("rst_out_y", out_y, 0);
        chk("rst_alu_op", alu_op, 4'hE);

        // ADD with writeback, plus issue latency
        @(posedge clk); #1;
        send(4'h0, 8'hF0, 8'h20, 1'b0, 1'b1, 8'h10, 1'b1);
        @(negedge clk);
        chk("lat_out_valid", out_valid, 0);
        chk("lat_alu_a", alu_a, 8'hF0);
        wait_idle();
        chk("add_acc", acc, 8'h10);

        // Chained PASS then SUB from accumulator
        @(posedge clk); #1;
        send(4'hF, 8'h05, 8'h00, 1'b0, 1'b1, 8'h05, 1'b0);
        send(4'h1, 8'hAA, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0);
        wait_idle();
        chk("chain_acc", acc, 8'hFE);

        // Backpressure: 5 accepted, 6th blocked, then drain at full rate
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            send(4'h0, W'(i), 8'h01, 1'b0, 1'b0, W'(i + 1), 1'b0);
        end
        in_valid = 1'b1;
        in_op = 4'h0; in_a = 8'h06; in_b = 8'h01; in_use_acc = 1'b0; in_wb = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
        end
        chk("bp_busy", busy, 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        fork
            send(4'h0, 8'h06, 8'h01, 1'b0, 1'b0, 8'h07, 1'b0);
            begin
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk);
                    chk("bp_stream", out_valid, 1);
                end
            end
        join
        wait_idle();
        chk("bp_in_ready_back", in_ready, 1);

        // Simultaneous push and issue at count 2
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(4'h0, 8'h10, 8'h01, 1'b0, 1'b0, 8'h11, 1'b0);
        send(4'h0, 8'h20, 8'h02, 1'b0, 1'b0, 8'h22, 1'b0);
        send(4'h0, 8'h30, 8'h03, 1'b0, 1'b0, 8'h33, 1'b0);
        out_ready = 1'b1;
        send(4'h1, 8'h40, 8'h04, 1'b0, 1'b0, 8'h3C, 1'b1);
        send(4'h0, 8'hFF, 8'h02, 1'b0, 1'b0, 8'h01, 1'b1);
        wait_idle();

        // Reset mid-operation
        out_ready = 1'b0;
        @(posedge clk); #1;
        send(4'h0, 8'h03, 8'h04, 1'b0, 1'b1, 8'h07, 1'b0);
        send(4'h0, 8'h01, 8'h01, 1'b0, 1'b1, 8'h02, 1'b0);
        send(4'h0, 8'h02, 8'h02, 1'b0, 1'b1, 8'h04, 1'b0);
        send(4'h0, 8'h03, 8'h03, 1'b0, 1'b1, 8'h06, 1'b0);
        @(negedge clk);
        chk("pre_rst_acc", acc, 8'h07);
        chk("pre_rst_valid", out_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_acc", acc, 0);
        chk("mid_rst_busy", busy, 0);
        sb.delete();
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_no_result", out_valid, 0);
        end

        // After reset: acc starts from 0, then a carry-producing ADD
        @(posedge clk); #1;
        send(4'h0, 8'h99, 8'h01, 1'b1, 1'b1, 8'h01, 1'b0);
        send(4'h0, 8'hF0, 8'h20, 1'b0, 1'b0, 8'h10, 1'b1);
        wait_idle();
        chk("post_rst_acc", acc, 8'h01);
`ifdef ALU_ISSUE_CTRL_STATS_EN
        chk("issue_cnt", issue_cnt, 2);
        chk("carry_cnt", carry_cnt, 1);
        chk("stall_cnt", stall_cnt, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
